// File: rtl/load_return_scoreboard_if.sv
// load_return_scoreboard_if
//
// Purpose: groups every non-clock/reset signal of the load-return scoreboard.
//   The pipeline side uses the master modport. The scoreboard uses the slave
//   modport.
//
// Handshake semantics (the only valid/ready pair on this bundle):
//   - ISSUE_VALID/ISSUE_READY: a load is allocated on a rising CLK edge when
//     both are 1 in the cycle before that edge. ISSUE_READY depends only on
//     the scoreboard's registered occupancy, never on ISSUE_VALID. An
//     ISSUE_VALID seen while ISSUE_READY=0 is dropped, not held.
//   - RESP_VALID has no ready. It is a one-cycle pulse carrying RESP_DATA for
//     the oldest outstanding load.
//
// Signal summary
//   Issue:  ISSUE_VALID, ISSUE_RD (pipeline -> sb), ISSUE_READY (sb -> pipeline)
//   Return: RESP_VALID, RESP_DATA (memory/network -> sb)
//   Query:  Q_RS1, Q_RS2, Q_USE_RS1, Q_USE_RS2, Q_STORE (stage 3 -> sb)
//   Result: STALL, FWD1_EN, FWD1_DATA, FWD2_EN, FWD2_DATA (sb -> stage 3)
//   Retire: WB_VALID, WB_RD, WB_DATA (sb -> register file)
//   Status: ERR_SPURIOUS (sticky)
interface load_return_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  ISSUE_VALID;
  logic [REG_ADDR_W-1:0] ISSUE_RD;
  logic                  ISSUE_READY;
  logic                  RESP_VALID;
  logic [DATA_W-1:0]     RESP_DATA;
  logic [REG_ADDR_W-1:0] Q_RS1;
  logic [REG_ADDR_W-1:0] Q_RS2;
  logic                  Q_USE_RS1;
  logic                  Q_USE_RS2;
  logic                  Q_STORE;
  logic                  STALL;
  logic                  FWD1_EN;
  logic [DATA_W-1:0]     FWD1_DATA;
  logic                  FWD2_EN;
  logic [DATA_W-1:0]     FWD2_DATA;
  logic                  WB_VALID;
  logic [REG_ADDR_W-1:0] WB_RD;
  logic [DATA_W-1:0]     WB_DATA;
  logic                  ERR_SPURIOUS;

  modport master (
    output ISSUE_VALID, ISSUE_RD, RESP_VALID, RESP_DATA,
           Q_RS1, Q_RS2, Q_USE_RS1, Q_USE_RS2, Q_STORE,
    input  ISSUE_READY, STALL, FWD1_EN, FWD1_DATA, FWD2_EN, FWD2_DATA,
           WB_VALID, WB_RD, WB_DATA, ERR_SPURIOUS
  );

  modport slave (
    input  ISSUE_VALID, ISSUE_RD, RESP_VALID, RESP_DATA,
           Q_RS1, Q_RS2, Q_USE_RS1, Q_USE_RS2, Q_STORE,
    output ISSUE_READY, STALL, FWD1_EN, FWD1_DATA, FWD2_EN, FWD2_DATA,
           WB_VALID, WB_RD, WB_DATA, ERR_SPURIOUS
  );
endinterface

// File: rtl/load_return_scoreboard.sv
// load_return_scoreboard
//
// Purpose: tracks variable-latency loads from issue in stage 4 until their
//   in-order data return. Stage-3 operands that name a still-outstanding load
//   destination stall the pipeline. Operands whose load data has returned but
//   not yet retired are forwarded. With STORE_LATE_BYPASS=1, the store-data
//   operand (rs2 of a store) may take response data in the same cycle it
//   returns.
//
// Ports
//   CLK    in  rising-edge clock
//   RESET  in  synchronous, active-high reset
//   bus    load_return_scoreboard_if.slave (issue, return, query, forward,
//          retire and error signals; see the interface header)
//
// Parameters
//   REG_ADDR_W, DATA_W   register address / data widths (must match the bus)
//   DEPTH                maximum outstanding loads, power of two, >= 2
//   STORE_LATE_BYPASS    1 = store data may bypass from RESP_DATA
module load_return_scoreboard #(
  parameter int REG_ADDR_W        = 5,
  parameter int DATA_W            = 32,
  parameter int DEPTH             = 4,
  parameter bit STORE_LATE_BYPASS = 1'b1
) (
  input logic                    CLK,
  input logic                    RESET,
  load_return_scoreboard_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Entry storage. An entry is valid when its age offset from head is below
  // count. The done bit is only meaningful for valid entries.
  logic [REG_ADDR_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0]     ent_data [DEPTH];
  logic [DEPTH-1:0]      ent_done;

  ptr_t head;     // oldest valid entry
  ptr_t tail;     // next slot to allocate
  ptr_t fill;     // oldest not-done entry (next response target)
  cnt_t count;    // valid entries
  cnt_t pend;     // valid entries still waiting for data
  logic err_spurious;

  logic issue_ready;
  logic issue_fire;
  logic resp_fire;
  logic retire;

  // Per-operand lookup results, index 0 = rs1, 1 = rs2.
  logic [REG_ADDR_W-1:0] q_rs      [2];
  logic                  q_use     [2];
  logic                  req       [2];
  logic                  hit_ent   [2];
  ptr_t                  hit_idx   [2];
  logic                  hit_issue [2];
  logic                  pending   [2];
  logic                  fwd_ok    [2];
  logic                  late2;
  logic                  stall;

  // Occupancy is registered, so a retire in this cycle does not free a slot
  // for an issue in the same cycle.
  assign issue_ready = (count < cnt_t'(DEPTH));
  assign issue_fire  = bus.ISSUE_VALID && issue_ready;
  // A response fills an entry only if one is waiting; otherwise it is spurious.
  assign resp_fire   = bus.RESP_VALID && (pend != '0);
  assign retire      = (count != '0) && ent_done[head];

  assign q_rs[0]  = bus.Q_RS1;
  assign q_rs[1]  = bus.Q_RS2;
  assign q_use[0] = bus.Q_USE_RS1;
  assign q_use[1] = bus.Q_USE_RS2;

  // Youngest-match search. Entries are scanned oldest to youngest, so a later
  // hit overrides an earlier one. An accepted same-cycle issue is younger than
  // every stored entry, so it is tracked separately and takes priority.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      hit_ent[n]   = 1'b0;
      hit_idx[n]   = '0;
      req[n]       = q_use[n] && (q_rs[n] != '0);
      hit_issue[n] = issue_fire && (bus.ISSUE_RD == q_rs[n]);
      for (int k = 0; k < DEPTH; k++) begin
        if ((cnt_t'(k) < count) && (ent_rd[head + ptr_t'(k)] == q_rs[n])) begin
          hit_ent[n] = 1'b1;
          hit_idx[n] = head + ptr_t'(k);
        end
      end
      pending[n] = req[n] && (hit_issue[n] || (hit_ent[n] && !ent_done[hit_idx[n]]));
      fwd_ok[n]  = req[n] && !hit_issue[n] && hit_ent[n] && ent_done[hit_idx[n]];
    end
  end

  // Store data may take the response in flight, but only if the response
  // fills exactly the entry the operand is waiting on. If rs1 is pending, the
  // instruction stalls anyway, so the bypass is suppressed.
  always_comb begin
    late2 = STORE_LATE_BYPASS && bus.Q_STORE && resp_fire && pending[1]
            && !hit_issue[1] && (hit_idx[1] == fill) && !pending[0];
    stall = pending[0] || (pending[1] && !late2);
  end

  always_comb begin
    bus.STALL     = stall;
    bus.FWD1_EN   = 1'b0;
    bus.FWD1_DATA = '0;
    bus.FWD2_EN   = 1'b0;
    bus.FWD2_DATA = '0;
    if (!stall) begin
      if (fwd_ok[0]) begin
        bus.FWD1_EN   = 1'b1;
        bus.FWD1_DATA = ent_data[hit_idx[0]];
      end
      if (late2) begin
        bus.FWD2_EN   = 1'b1;
        bus.FWD2_DATA = bus.RESP_DATA;
      end else if (fwd_ok[1]) begin
        bus.FWD2_EN   = 1'b1;
        bus.FWD2_DATA = ent_data[hit_idx[1]];
      end
    end
  end

  // Writeback of the head entry. Loads to r0 still retire (freeing the slot)
  // but are not presented to the register file.
  always_comb begin
    bus.WB_VALID = retire && (ent_rd[head] != '0);
    bus.WB_RD    = '0;
    bus.WB_DATA  = '0;
    if (bus.WB_VALID) begin
      bus.WB_RD   = ent_rd[head];
      bus.WB_DATA = ent_data[head];
    end
  end

  assign bus.ISSUE_READY  = issue_ready;
  assign bus.ERR_SPURIOUS = err_spurious;

  // Issue writes the tail slot and the response writes the fill slot. These
  // never coincide: a response needs a valid not-done entry, and the tail is
  // only valid when the buffer is full, which blocks issue.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head         <= '0;
      tail         <= '0;
      fill         <= '0;
      count        <= '0;
      pend         <= '0;
      ent_done     <= '0;
      err_spurious <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (issue_fire) begin
        ent_rd[tail]   <= bus.ISSUE_RD;
        ent_done[tail] <= 1'b0;
        tail           <= tail + ptr_t'(1);
      end
      if (resp_fire) begin
        ent_data[fill] <= bus.RESP_DATA;
        ent_done[fill] <= 1'b1;
        fill           <= fill + ptr_t'(1);
      end
      if (retire) begin
        head <= head + ptr_t'(1);
      end
      count <= count + cnt_t'(issue_fire) - cnt_t'(retire);
      pend  <= pend + cnt_t'(issue_fire) - cnt_t'(resp_fire);
      if (bus.RESP_VALID && (pend == '0)) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_return_scoreboard.sv
module tb_load_return_scoreboard;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int failed    = 0;

  // Scoreboard: exp_q holds {rd, data} writebacks in expected order;
  // pend_q holds rd of accepted loads still waiting for data.
  logic [RW+DW-1:0] exp_q[$];
  logic [RW-1:0]    pend_q[$];
  logic [RW+DW-1:0] mon_exp;

  load_return_scoreboard_if #(.REG_ADDR_W(RW), .DATA_W(DW)) bus ();
  load_return_scoreboard_if #(.REG_ADDR_W(RW), .DATA_W(DW)) bus_nb ();

  // Second instance without late bypass sees identical stimulus.
  assign bus_nb.ISSUE_VALID = bus.ISSUE_VALID;
  assign bus_nb.ISSUE_RD    = bus.ISSUE_RD;
  assign bus_nb.RESP_VALID  = bus.RESP_VALID;
  assign bus_nb.RESP_DATA   = bus.RESP_DATA;
  assign bus_nb.Q_RS1       = bus.Q_RS1;
  assign bus_nb.Q_RS2       = bus.Q_RS2;
  assign bus_nb.Q_USE_RS1   = bus.Q_USE_RS1;
  assign bus_nb.Q_USE_RS2   = bus.Q_USE_RS2;
  assign bus_nb.Q_STORE     = bus.Q_STORE;

  load_return_scoreboard #(.REG_ADDR_W(RW), .DATA_W(DW), .DEPTH(DEPTH),
                           .STORE_LATE_BYPASS(1'b1))
    dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  load_return_scoreboard #(.REG_ADDR_W(RW), .DATA_W(DW), .DEPTH(DEPTH),
                           .STORE_LATE_BYPASS(1'b0))
    dut_nb (.CLK(CLK), .RESET(RESET), .bus(bus_nb));

  // ---------------- clock / reset helpers ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle;
    bus.ISSUE_VALID = 1'b0;
    bus.ISSUE_RD    = '0;
    bus.RESP_VALID  = 1'b0;
    bus.RESP_DATA   = '0;
    bus.Q_RS1       = '0;
    bus.Q_RS2       = '0;
    bus.Q_USE_RS1   = 1'b0;
    bus.Q_USE_RS2   = 1'b0;
    bus.Q_STORE     = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    drive_idle();
    pend_q.delete();
    exp_q.delete();
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic drive_issue(input logic [RW-1:0] rd, input bit accept);
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_RD    = rd;
    if (accept) pend_q.push_back(rd);
  endtask

  task automatic drive_resp(input logic [DW-1:0] d);
    logic [RW-1:0] rd;
    bus.RESP_VALID = 1'b1;
    bus.RESP_DATA  = d;
    if (pend_q.size() > 0) begin
      rd = pend_q.pop_front();
      if (rd != '0) exp_q.push_back({rd, d});
    end
  endtask

  task automatic drive_query(input logic [RW-1:0] rs1, input logic use1,
                             input logic [RW-1:0] rs2, input logic use2,
                             input logic store);
    bus.Q_RS1     = rs1;
    bus.Q_USE_RS1 = use1;
    bus.Q_RS2     = rs2;
    bus.Q_USE_RS2 = use2;
    bus.Q_STORE   = store;
  endtask

  // ---------------- writeback scoreboard ----------------
  always @(negedge CLK) begin
    if (RESET === 1'b0 && bus.WB_VALID === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback",
                 bus.WB_RD, bus.WB_DATA);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.WB_RD, bus.WB_DATA} !== mon_exp) begin
          failed++;
          $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   bus.WB_RD, bus.WB_DATA, mon_exp[RW+DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset();
    settle();
    tests_run++;
    if ({bus.ISSUE_READY, bus.STALL, bus.FWD1_EN, bus.FWD2_EN, bus.WB_VALID,
         bus.ERR_SPURIOUS} !== 6'b100000) begin
      failed++;
      $display("FAIL reset_flags: got %b, required 100000",
               {bus.ISSUE_READY, bus.STALL, bus.FWD1_EN, bus.FWD2_EN,
                bus.WB_VALID, bus.ERR_SPURIOUS});
    end
    tests_run++;
    if ({bus.FWD1_DATA, bus.FWD2_DATA, bus.WB_RD, bus.WB_DATA} !== '0) begin
      failed++;
      $display("FAIL reset_data: got f1=%h f2=%h rd=%0d wb=%h, required all 0",
               bus.FWD1_DATA, bus.FWD2_DATA, bus.WB_RD, bus.WB_DATA);
    end
  endtask

  task automatic test_basic_forward;
    tick(); drive_idle(); drive_issue(5'd5, 1'b1); settle();
    tests_run++;
    if (bus.ISSUE_READY !== 1'b1) begin
      failed++; $display("FAIL basic_ready: got %b, required 1", bus.ISSUE_READY);
    end
    tick(); drive_idle(); drive_query(5'd5, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD1_EN} !== 2'b10) begin
      failed++; $display("FAIL basic_stall: got stall/fwd=%b, required 10", {bus.STALL, bus.FWD1_EN});
    end
    tick(); drive_idle(); drive_query(5'd5, 1, 5'd0, 0, 0); drive_resp(32'hDEADBEEF); settle();
    tests_run++;
    if (bus.STALL !== 1'b1) begin
      failed++; $display("FAIL basic_resp_cycle_stall: got %b, required 1", bus.STALL);
    end
    tick(); drive_idle(); drive_query(5'd5, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD1_EN, bus.FWD1_DATA} !== {2'b01, 32'hDEADBEEF}) begin
      failed++; $display("FAIL basic_fwd: got stall=%b en=%b data=%h, required 0 1 deadbeef",
                         bus.STALL, bus.FWD1_EN, bus.FWD1_DATA);
    end
    tests_run++;
    if ({bus.WB_VALID, bus.WB_RD} !== {1'b1, 5'd5}) begin
      failed++; $display("FAIL basic_wb: got valid=%b rd=%0d, required 1 5", bus.WB_VALID, bus.WB_RD);
    end
    tick(); drive_idle(); drive_query(5'd5, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD1_EN, bus.WB_VALID} !== 3'b000) begin
      failed++; $display("FAIL basic_after_retire: got %b, required 000",
                         {bus.STALL, bus.FWD1_EN, bus.WB_VALID});
    end
  endtask

  task automatic test_youngest;
    tick(); drive_idle(); drive_issue(5'd7, 1'b1);
    tick(); drive_idle(); drive_issue(5'd7, 1'b1);
    tick(); drive_idle(); drive_resp(32'h11);
    tick(); drive_idle(); drive_query(5'd0, 0, 5'd7, 1, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD2_EN, bus.WB_VALID, bus.WB_RD} !== {3'b101, 5'd7}) begin
      failed++; $display("FAIL youngest_pending: got stall=%b en=%b wb=%b rd=%0d, required 1 0 1 7",
                         bus.STALL, bus.FWD2_EN, bus.WB_VALID, bus.WB_RD);
    end
    tick(); drive_idle(); drive_query(5'd0, 0, 5'd7, 1, 0); drive_resp(32'h22); settle();
    tests_run++;
    if (bus.STALL !== 1'b1) begin
      failed++; $display("FAIL youngest_nonstore_resp: got stall=%b, required 1", bus.STALL);
    end
    tick(); drive_idle(); drive_query(5'd0, 0, 5'd7, 1, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD2_EN, bus.FWD2_DATA} !== {2'b01, 32'h22}) begin
      failed++; $display("FAIL youngest_fwd: got stall=%b en=%b data=%h, required 0 1 00000022",
                         bus.STALL, bus.FWD2_EN, bus.FWD2_DATA);
    end
    // Same-cycle issue of the queried register always stalls.
    tick(); drive_idle(); drive_issue(5'd12, 1'b1); drive_query(5'd12, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if (bus.STALL !== 1'b1) begin
      failed++; $display("FAIL same_cycle_issue: got stall=%b, required 1", bus.STALL);
    end
    tick(); drive_idle(); drive_resp(32'h1234);
    tick(); drive_idle();
    tick(); drive_idle();
  endtask

  task automatic test_late_bypass;
    tick(); drive_idle(); drive_issue(5'd9, 1'b1);
    tick(); drive_idle(); drive_query(5'd0, 0, 5'd9, 1, 1); drive_resp(32'hCAFE0001); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD2_EN, bus.FWD2_DATA} !== {2'b01, 32'hCAFE0001}) begin
      failed++; $display("FAIL bypass_on: got stall=%b en=%b data=%h, required 0 1 cafe0001",
                         bus.STALL, bus.FWD2_EN, bus.FWD2_DATA);
    end
    tests_run++;
    if ({bus_nb.STALL, bus_nb.FWD2_EN} !== 2'b10) begin
      failed++; $display("FAIL bypass_off: got stall/en=%b, required 10", {bus_nb.STALL, bus_nb.FWD2_EN});
    end
    tick(); drive_idle(); settle();
    tests_run++;
    if ({bus_nb.WB_VALID, bus_nb.WB_RD, bus_nb.WB_DATA} !== {1'b1, 5'd9, 32'hCAFE0001}) begin
      failed++; $display("FAIL bypass_off_wb: got %b %0d %h, required 1 9 cafe0001",
                         bus_nb.WB_VALID, bus_nb.WB_RD, bus_nb.WB_DATA);
    end
    // rs1 also pending on the same register: stall wins.
    tick(); drive_idle(); drive_issue(5'd9, 1'b1);
    tick(); drive_idle(); drive_query(5'd9, 1, 5'd9, 1, 1); drive_resp(32'hCAFE0002); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD2_EN} !== 2'b10) begin
      failed++; $display("FAIL bypass_rs1_pending: got stall/en=%b, required 10", {bus.STALL, bus.FWD2_EN});
    end
    // Response fills an older entry, not the one rs2 waits on.
    tick(); drive_idle(); drive_issue(5'd9, 1'b1);
    tick(); drive_idle(); drive_issue(5'd10, 1'b1);
    tick(); drive_idle(); drive_query(5'd0, 0, 5'd10, 1, 1); drive_resp(32'hCAFE0003); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD2_EN} !== 2'b10) begin
      failed++; $display("FAIL bypass_wrong_entry: got stall/en=%b, required 10", {bus.STALL, bus.FWD2_EN});
    end
    tick(); drive_idle(); drive_resp(32'hCAFE0004);
    tick(); drive_idle();
    tick(); drive_idle();
  endtask

  task automatic test_full_wrap;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      tick(); drive_idle(); drive_issue(5'(10 + i), 1'b1); settle();
      tests_run++;
      if (bus.ISSUE_READY !== 1'b1) begin
        failed++; $display("FAIL full_ready_%0d: got %b, required 1", i, bus.ISSUE_READY);
      end
    end
    tick(); drive_idle(); drive_issue(5'd20, 1'b0); drive_query(5'd20, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if ({bus.ISSUE_READY, bus.STALL} !== 2'b00) begin
      failed++; $display("FAIL full_drop: got ready/stall=%b, required 00", {bus.ISSUE_READY, bus.STALL});
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(); drive_idle();
      d = 32'($urandom());
      drive_resp(d); settle();
      if (i == 1) begin
        tests_run++;
        if (bus.ISSUE_READY !== 1'b0) begin
          failed++; $display("FAIL full_no_same_cycle_credit: got %b, required 0", bus.ISSUE_READY);
        end
      end
    end
    tick(); drive_idle();
    tick(); drive_idle(); drive_query(5'd13, 1, 5'd10, 1, 0); settle();
    tests_run++;
    if ({bus.ISSUE_READY, bus.STALL, bus.FWD1_EN, bus.FWD2_EN, bus.WB_VALID} !== 5'b10000) begin
      failed++; $display("FAIL full_drained: got %b, required 10000",
                         {bus.ISSUE_READY, bus.STALL, bus.FWD1_EN, bus.FWD2_EN, bus.WB_VALID});
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++; $display("FAIL wb_missing: got %0d pending writebacks, required 0", exp_q.size());
    end
  endtask

  task automatic test_rd0_spurious;
    tick(); drive_idle(); drive_issue(5'd0, 1'b1);
    tick(); drive_idle(); drive_query(5'd0, 1, 5'd0, 1, 1); settle();
    tests_run++;
    if ({bus.STALL, bus.FWD1_EN, bus.FWD2_EN} !== 3'b000) begin
      failed++; $display("FAIL rd0_query: got %b, required 000", {bus.STALL, bus.FWD1_EN, bus.FWD2_EN});
    end
    tick(); drive_idle(); drive_resp(32'h55);
    tick(); drive_idle(); settle();
    tests_run++;
    if ({bus.WB_VALID, bus.ERR_SPURIOUS} !== 2'b00) begin
      failed++; $display("FAIL rd0_retire: got wb/err=%b, required 00", {bus.WB_VALID, bus.ERR_SPURIOUS});
    end
    tick(); drive_idle(); drive_resp(32'h66); settle();
    tests_run++;
    if (bus.ERR_SPURIOUS !== 1'b0) begin
      failed++; $display("FAIL spurious_early: got %b, required 0", bus.ERR_SPURIOUS);
    end
    tick(); drive_idle(); settle();
    tests_run++;
    if (bus.ERR_SPURIOUS !== 1'b1) begin
      failed++; $display("FAIL spurious_set: got %b, required 1", bus.ERR_SPURIOUS);
    end
    repeat (3) tick();
    settle();
    tests_run++;
    if (bus.ERR_SPURIOUS !== 1'b1) begin
      failed++; $display("FAIL spurious_sticky: got %b, required 1", bus.ERR_SPURIOUS);
    end
    // Reset discards an outstanding load; its late response is spurious.
    tick(); drive_idle(); drive_issue(5'd3, 1'b1);
    tick(); do_reset(); drive_query(5'd3, 1, 5'd0, 0, 0); settle();
    tests_run++;
    if ({bus.STALL, bus.ERR_SPURIOUS, bus.ISSUE_READY} !== 3'b001) begin
      failed++; $display("FAIL reset_discard: got stall/err/ready=%b, required 001",
                         {bus.STALL, bus.ERR_SPURIOUS, bus.ISSUE_READY});
    end
    tick(); drive_idle(); drive_resp(32'h77);
    tick(); drive_idle(); settle();
    tests_run++;
    if (bus.ERR_SPURIOUS !== 1'b1) begin
      failed++; $display("FAIL spurious_after_reset: got %b, required 1", bus.ERR_SPURIOUS);
    end
    do_reset(); settle();
    tests_run++;
    if (bus.ERR_SPURIOUS !== 1'b0) begin
      failed++; $display("FAIL spurious_cleared: got %b, required 0", bus.ERR_SPURIOUS);
    end
  endtask

  initial begin
    RESET = 1'b1;
    drive_idle();
    test_reset();
    test_basic_forward();
    test_youngest();
    test_late_bypass();
    test_full_wrap();
    test_rd0_spurious();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_return_scoreboard.md
# load_return_scoreboard

Tracks variable-latency loads (data-memory reads and network-interface reads) between issue in stage 4 and their in-order data return, so stage 3 consumers stall only while data is truly outstanding and receive forwarded data once it has returned. Generalises stage-4 load-to-store forwarding: multiple outstanding loads, parametrised widths, and both rs1 and rs2 checking. A late-bypass mode lets store-data operands take returning data in the same cycle instead of stalling. Sits beside the stage-4 forward unit, driving the pipeline stall and the stage-3 operand muxes.

## Interface
- REG_ADDR_W, 5, register address width
- DATA_W, 32, data width
- DEPTH, 4, max outstanding loads (power of two, ≥2)
- STORE_LATE_BYPASS, 1, 1 = rs2 of a store may take same-cycle response data

- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ISSUE_VALID  in  1  load issued this cycle (mem or net read)
- ISSUE_RD  in  REG_ADDR_W  load destination register
- ISSUE_READY  out  1  scoreboard can accept an issue
- RESP_VALID  in  1  load data returning (strictly issue order, mem and net share the order)
- RESP_DATA  in  DATA_W  returned data
- Q_RS1, Q_RS2  in  REG_ADDR_W  stage-3 source registers
- Q_USE_RS1, Q_USE_RS2  in  1  operand actually read
- Q_STORE  in  1  stage-3 instruction is a store (mem write or net write); rs2 is store data
- STALL  out  1  hold stage 3 and earlier
- FWD1_EN, FWD2_EN  out  1  select forwarded operand
- FWD1_DATA, FWD2_DATA  out  DATA_W  forwarded operand
- WB_VALID  out  1  head load retires to register file this cycle
- WB_RD  out  REG_ADDR_W  retiring destination
- WB_DATA  out  DATA_W  retiring data
- ERR_SPURIOUS  out  1  sticky: response arrived with no pending entry

## Operation
- Circular buffer of DEPTH entries {rd, done, data}; head/tail pointers plus count (width clog2(DEPTH)+1); pointers wrap modulo DEPTH.
- Issue: ISSUE_VALID && ISSUE_READY allocates at tail with done=0. ISSUE_READY = (count < DEPTH); no same-cycle credit from retire. Issue while not ready is dropped.
- Response fills the oldest not-done entry (fill pointer between head and tail). Response with no not-done entry: ignored, ERR_SPURIOUS set until RESET.
- Retire: when head entry done, WB_VALID=1 with its rd/data; head advances at the edge. At most one retire per cycle. rd=0 entries retire with WB_VALID=0.
- Match for operand n (n=1,2): Q_USE_RSn, Q_RSn≠0, and equal to rd of a valid entry or of the same-cycle issue; the youngest match wins (same-cycle issue is youngest).
  - Youngest match done: FWDn_EN=1, FWDn_DATA=entry data.
  - Youngest match not done: STALL=1, unless STORE_LATE_BYPASS=1, n=2, Q_STORE=1, the match is the entry the current RESP_VALID fills, and the operand is not also rs1-matched pending; then FWD2_EN=1, FWD2_DATA=RESP_DATA, no stall from rs2.
  - Match on same-cycle issue always stalls.
- STALL = OR of per-operand stall conditions; FWDn_EN forced 0 when STALL=1.
- Issue, response, and retire are independent and may all occur in one cycle; count updates by +issue −retire.

## Timing
- Reset values: count=0, pointers=0, all done=0, ISSUE_READY=1, STALL=0, FWDn_EN=0, FWDn_DATA=0, WB_VALID=0, WB_RD=0, WB_DATA=0, ERR_SPURIOUS=0.
- STALL, FWDn_*, WB_*, ISSUE_READY are combinational from state and current inputs; all state updates on the CLK edge.
- Response sampled at edge ending cycle t → entry done in t+1 → forwardable and WB_VALID in t+1 if at head → removed at edge ending t+1; register file supplies from t+2.
- RESET mid-operation discards all entries; responses for discarded loads after reset set ERR_SPURIOUS.

## Test plan
- Reset, then idle: all outputs at reset values, ISSUE_READY=1.
- Issue rd=5; next cycle Q_RS1=5 → STALL=1; RESP_DATA=0xDEADBEEF cycle later → next cycle FWD1_EN=1, FWD1_DATA=0xDEADBEEF, WB_VALID=1, WB_RD=5; following cycle no match.
- Issue rd=7 twice (loads A then B), respond A=0x11 only → Q_RS2=7 stalls (youngest B pending); respond B=0x22 → FWD2_DATA=0x22.
- Q_STORE=1, Q_RS2=9 pending, RESP_VALID with 0xCAFE0001 same cycle → STALL=0, FWD2_EN=1, FWD2_DATA=0xCAFE0001; repeat with STORE_LATE_BYPASS=0 → STALL=1.
- Issue DEPTH loads without responses → ISSUE_READY=0, extra issue dropped; respond all → WB pulses in issue order, pointers wrap, count back to 0.
- Issue rd=0 and query rs=0 → no stall, no WB_VALID; RESP_VALID with empty buffer → ERR_SPURIOUS=1 held until RESET.
